// File: rtl/router_pkg.sv
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared definitions for the router egress arbiter: channel
//             count, FSM state encoding, header field positions and small
//             helpers for channel-index arithmetic.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int NUM_CH   = 3;

  // Header byte layout: {len[7:2], addr[1:0]}
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    PAR  = 2'd3
  } state_e;

  // Round-robin successor of a channel index, modulo NUM_CH.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Index of the set bit of a one-hot grant (0 when no bit is set).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_rr_pick.sv
// ============================================================================
//  Module   : router_rr_pick
//  Purpose  : Combinational 3-way round-robin picker. Returns the one-hot
//             grant of the first requesting channel at or after ptr_i,
//             wrapping modulo 3.
//  Ports    : req_i [2:0]  per-channel request
//             ptr_i [1:0]  highest-priority channel index (0..2)
//             gnt_o [2:0]  one-hot grant, zero when nothing requests
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_rr_pick
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [1:0]        ptr_i,
  output logic [NUM_CH-1:0] gnt_o
);

  logic [NUM_CH-1:0] req_rot;
  logic [NUM_CH-1:0] gnt_rot;

  // Rotate requests so that channel ptr_i lands on bit 0, run a fixed
  // LSB-first priority pick, then rotate the grant back.
  always_comb begin
    case (ptr_i)
      2'd1:    req_rot = {req_i[0], req_i[2:1]};
      2'd2:    req_rot = {req_i[1:0], req_i[2]};
      default: req_rot = req_i;
    endcase

    if (req_rot[0])      gnt_rot = 3'b001;
    else if (req_rot[1]) gnt_rot = 3'b010;
    else if (req_rot[2]) gnt_rot = 3'b100;
    else                 gnt_rot = 3'b000;

    case (ptr_i)
      2'd1:    gnt_o = {gnt_rot[1:0], gnt_rot[2]};
      2'd2:    gnt_o = {gnt_rot[0], gnt_rot[2], gnt_rot[1]};
      default: gnt_o = gnt_rot;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/router_egress_arb.sv
// ============================================================================
//  Module   : router_egress_arb
//  Purpose  : Drains three first-word-fall-through router FIFOs onto one
//             egress link, one whole packet at a time, with packet-level
//             round-robin arbitration and a per-packet stall timeout that
//             soft-resets the granted FIFO and aborts the packet.
//             Packet: header {len,addr}, len payload bytes, parity byte.
//  Ports    : clock_i, reset_i          clock, synchronous active-high reset
//             fifo_empty_i[2:0]         per-channel empty flags
//             fifo_dout_{0,1,2}_i       head-of-FIFO bytes
//             read_enb_o[2:0]           pop strobe (one-hot or zero)
//             egress_ready_i            downstream accept
//             egress_valid_o/data_o     registered egress beat
//             egress_sop_o/eop_o        header / parity beat markers
//             egress_abort_o            packet truncated by timeout (pulse)
//             grant_o[2:0]              channel owning the link
//             soft_reset_o[2:0]         timed-out channel FIFO reset (pulse)
//             parity_err_o              parity mismatch on the eop beat
//  Config   : ROUTER_ARB_PARITY_CHK_EN  enables the running-XOR parity check;
//             when undefined parity_err_o is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_egress_arb
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
)(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_0_i,
  input  logic [DATA_W-1:0] fifo_dout_1_i,
  input  logic [DATA_W-1:0] fifo_dout_2_i,
  output logic [NUM_CH-1:0] read_enb_o,
  input  logic              egress_ready_i,
  output logic              egress_valid_o,
  output logic [DATA_W-1:0] egress_data_o,
  output logic              egress_sop_o,
  output logic              egress_eop_o,
  output logic              egress_abort_o,
  output logic [NUM_CH-1:0] grant_o,
  output logic [NUM_CH-1:0] soft_reset_o,
  output logic              parity_err_o
);

  state_e             state_q,   state_d;
  logic [NUM_CH-1:0]  grant_q,   grant_d;
  logic [1:0]         rr_ptr_q,  rr_ptr_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,  to_cnt_d;
  logic [DATA_W-1:0]  data_q,    data_d;
  logic               valid_q,   valid_d;
  logic               sop_q,     sop_d;
  logic               eop_q,     eop_d;

  logic [NUM_CH-1:0]  pick;
  logic [DATA_W-1:0]  head_dout;
  logic               head_avail;
  logic               active;
  logic               pop;
  logic               timeout;

  router_rr_pick u_pick (
    .req_i (~fifo_empty_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    head_dout = '0;
    if (grant_q[0]) head_dout = fifo_dout_0_i;
    if (grant_q[1]) head_dout = fifo_dout_1_i;
    if (grant_q[2]) head_dout = fifo_dout_2_i;
  end

  assign head_avail = |(grant_q & ~fifo_empty_i);
  assign active     = (state_q != IDLE);

  // Strobes are gated by reset so a reset cycle never pops a FIFO or
  // fires a soft_reset/abort, even if the timeout counter happens to be full.
  assign pop     = !reset_i && active && head_avail && (!valid_q || egress_ready_i);
  assign timeout = !reset_i && active && !pop && (to_cnt_q == TO_W'(TIMEOUT - 1));

  assign read_enb_o     = pop     ? grant_q : '0;
  assign soft_reset_o   = timeout ? grant_q : '0;
  assign egress_abort_o = timeout;
  assign grant_o        = grant_q;
  assign egress_valid_o = valid_q;
  assign egress_data_o  = data_q;
  assign egress_sop_o   = sop_q;
  assign egress_eop_o   = eop_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    len_cnt_d = len_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;

    // Output register: load on pop, drop on accept or abort, else hold.
    if (pop) begin
      data_d  = head_dout;
      valid_d = 1'b1;
      sop_d   = (state_q == HDR);
      eop_d   = (state_q == PAR);
    end else if (timeout || (valid_q && egress_ready_i)) begin
      data_d  = '0;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end

    if (!active || pop) to_cnt_d = '0;
    else                to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (|(~fifo_empty_i)) begin
          grant_d = pick;
          state_d = HDR;
        end
      end
      HDR: begin
        if (pop) begin
          len_cnt_d = LEN_W'(head_dout[LEN_MSB:LEN_LSB]);
          state_d   = (len_cnt_d == '0) ? PAR : BODY;
        end
      end
      BODY: begin
        // BODY is only entered with len_cnt >= 1, so this cannot underflow.
        if (pop) begin
          len_cnt_d = len_cnt_q - 1'b1;
          if (len_cnt_q == LEN_W'(1)) state_d = PAR;
        end
      end
      PAR: begin
        if (pop) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr(onehot_to_idx(grant_q));
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d   = IDLE;
      grant_d   = '0;
      rr_ptr_d  = next_ptr(onehot_to_idx(grant_q));
      len_cnt_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      len_cnt_q <= '0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      len_cnt_q <= len_cnt_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
    end
  end

`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              perr_q, perr_d;

  // Running XOR restarts on the header; the flag is registered so it lines
  // up with the eop beat it describes.
  always_comb begin
    xor_d  = xor_q;
    perr_d = 1'b0;
    if (pop) begin
      case (state_q)
        HDR:     xor_d  = head_dout;
        BODY:    xor_d  = xor_q ^ head_dout;
        PAR:     perr_d = (xor_q != head_dout);
        default: xor_d  = xor_q;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      xor_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      xor_q  <= xor_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_router_egress_arb.sv
// ============================================================================
//  Module   : tb_router_egress_arb
//  Purpose  : Self-checking bench for router_egress_arb. FIFO models feed
//             directed packets; expected egress beats are queued when a
//             packet is loaded and a monitor compares each accepted beat.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_egress_arb;

  localparam bit PCHK =
`ifdef ROUTER_ARB_PARITY_CHK_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic       perr;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] fifo_empty;
  logic [7:0] dout0, dout1, dout2;
  logic [2:0] read_enb;
  logic       ready;
  logic       valid;
  logic [7:0] data;
  logic       sop, eop, abort_p, perr;
  logic [2:0] grant, soft_reset;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fq0[$], fq1[$], fq2[$];
  beat_t      exp_q[$];
  logic [2:0] rd_s = '0;
  logic [2:0] sr_s = '0;

  always #5 clock = ~clock;

  router_egress_arb dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .fifo_empty_i   (fifo_empty),
    .fifo_dout_0_i  (dout0),
    .fifo_dout_1_i  (dout1),
    .fifo_dout_2_i  (dout2),
    .read_enb_o     (read_enb),
    .egress_ready_i (ready),
    .egress_valid_o (valid),
    .egress_data_o  (data),
    .egress_sop_o   (sop),
    .egress_eop_o   (eop),
    .egress_abort_o (abort_p),
    .grant_o        (grant),
    .soft_reset_o   (soft_reset),
    .parity_err_o   (perr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    dout0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
    dout1 = (fq1.size() != 0) ? fq1[0] : 8'h00;
    dout2 = (fq2.size() != 0) ? fq2[0] : 8'h00;
  endtask

  task automatic push_fifo(input int ch, input logic [7:0] b);
    case (ch)
      0:       fq0.push_back(b);
      1:       fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
    refresh();
  endtask

  // Loads one packet into a FIFO; payload byte i is seed*(i+1). When track
  // is set the beats it must produce on egress are queued for the monitor.
  task automatic pkt(input int ch, input logic [7:0] hdr, input logic [7:0] seed,
                     input bit bad, input bit track);
    logic [7:0] b, x;
    int len;
    len = int'(hdr[7:2]);
    x   = hdr;
    push_fifo(ch, hdr);
    if (track) exp_q.push_back({1'b0, 1'b1, 1'b0, hdr});
    for (int i = 0; i < len; i++) begin
      b = 8'(seed * 8'(i + 1));
      x = x ^ b;
      push_fifo(ch, b);
      if (track) exp_q.push_back({1'b0, 1'b0, 1'b0, b});
    end
    b = x ^ (bad ? 8'h01 : 8'h00);
    push_fifo(ch, b);
    if (track) exp_q.push_back({bad & PCHK, 1'b0, 1'b1, b});
  endtask

  // FIFO model: strobes sampled mid-cycle are applied just after the edge.
  always @(negedge clock) begin
    rd_s = read_enb;
    sr_s = soft_reset;
  end

  always @(posedge clock) begin
    #1;
    if (rd_s[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (rd_s[1] && fq1.size() != 0) void'(fq1.pop_front());
    if (rd_s[2] && fq2.size() != 0) void'(fq2.pop_front());
    if (sr_s[0]) fq0.delete();
    if (sr_s[1]) fq1.delete();
    if (sr_s[2]) fq2.delete();
    refresh();
  end

  // Monitor: every accepted beat is compared against the next expectation.
  always @(negedge clock) begin
    beat_t e;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data 0x%0h sop %0b eop %0b, expected no beat",
                 data, sop, eop);
      end else begin
        e = exp_q.pop_front();
        chk("beat{perr,sop,eop,data}", {23'd0, perr, sop, eop, data}, {23'd0, e});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || valid) && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk(nm, exp_q.size(), 0);
    cyc();
  endtask

  task automatic window(input int ncyc, output int rdc, output int vc, output int span,
                        output int gcyc, output logic [2:0] gval);
    int first, last;
    first = -1; last = -1; rdc = 0; vc = 0; gcyc = -1; gval = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      if (read_enb != 3'b000) rdc++;
      if (valid) begin
        vc++;
        if (first < 0) first = i;
        last = i;
      end
      if (gcyc < 0 && grant != 3'b000) begin
        gcyc = i;
        gval = grant;
      end
    end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fq0.delete(); fq1.delete(); fq2.delete();
    refresh();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int rdc, vc, span, gcyc, k, nopop, n, zrun;
    logic [2:0] gval, prev;
    logic [2:0] gseq[3];
    int gaps[2];

    reset = 1'b1;
    ready = 1'b1;
    refresh();

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_outputs", {valid, data, sop, eop, abort_p, perr},  15'd0);
    chk("rst_grant_rd_sr", {grant, read_enb, soft_reset}, 9'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // 1: single packet on ch0
    pkt(0, 8'h0C, 8'h11, 1'b0, 1'b1);
    window(14, rdc, vc, span, gcyc, gval);
    chk("t1_grant_cycle", gcyc, 1);
    chk("t1_grant_val", gval, 3'b001);
    chk("t1_read_pulses", rdc, 5);
    chk("t1_beats", vc, 5);
    chk("t1_back_to_back", span, 5);
    drain("t1_drain");

    // 2: all three channels request at once
    do_reset();
    pkt(0, 8'h04, 8'hA1, 1'b0, 1'b1);
    pkt(1, 8'h05, 8'hB2, 1'b0, 1'b1);
    pkt(2, 8'h06, 8'hC3, 1'b0, 1'b1);
    n = 0; zrun = 0; prev = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (grant != 3'b000 && prev == 3'b000 && n < 3) begin
        gseq[n] = grant;
        if (n > 0) gaps[n-1] = zrun;
        n++;
      end
      zrun = (grant == 3'b000) ? zrun + 1 : 0;
      prev = grant;
    end
    chk("t2_num_grants", n, 3);
    chk("t2_grant0", gseq[0], 3'b001);
    chk("t2_grant1", gseq[1], 3'b010);
    chk("t2_grant2", gseq[2], 3'b100);
    chk("t2_gap0", gaps[0], 1);
    chk("t2_gap1", gaps[1], 1);
    drain("t2_drain");

    // 3: backpressure; ch0 and ch1 loaded together, pointer back at ch0
    pkt(0, 8'h10, 8'h21, 1'b0, 1'b1);
    pkt(1, 8'h05, 8'h55, 1'b0, 1'b1);
    for (k = 0; k < 40; k++) begin
      @(negedge clock);
      if (valid && data == 8'h42) break;
    end
    chk("t3_found_payload2", data, 8'h42);
    cyc();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t3_hold{valid,data,rd,sr}", {valid, data, read_enb, soft_reset}, {1'b1, 8'h63, 3'b000, 3'b000});
    end
    cyc();
    ready = 1'b1;
    drain("t3_drain");

    // 4: stall timeout on ch1 in BODY, ch2 waiting
    ready = 1'b0;
    pkt(1, 8'h21, 8'h05, 1'b0, 1'b0);
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (read_enb == 3'b010) break;
    end
    chk("t4_hdr_pop", read_enb, 3'b010);
    cyc();
    pkt(2, 8'h0A, 8'h07, 1'b0, 1'b1);
    nopop = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clock);
      if (read_enb == 3'b000) nopop++;
      if (soft_reset != 3'b000) break;
    end
    chk("t4_nopop_cycles", nopop, 30);
    chk("t4_soft_reset", soft_reset, 3'b010);
    chk("t4_abort", abort_p, 1'b1);
    @(negedge clock);
    chk("t4_after{grant,valid,abort,sr}", {grant, valid, abort_p, soft_reset}, 8'd0);
    @(negedge clock);
    chk("t4_next_grant", grant, 3'b100);
    cyc();
    ready = 1'b1;
    drain("t4_drain");

    // 5: zero-length packet on ch2
    pkt(2, 8'h02, 8'h00, 1'b0, 1'b1);
    window(10, rdc, vc, span, gcyc, gval);
    chk("t5_grant_val", gval, 3'b100);
    chk("t5_read_pulses", rdc, 2);
    chk("t5_beats", vc, 2);
    chk("t5_span", span, 2);
    drain("t5_drain");

    // 6: corrupted parity byte
    pkt(0, 8'h08, 8'h3C, 1'b1, 1'b1);
    drain("t6_drain");

    // 7: reset in the middle of a packet
    pkt(0, 8'h10, 8'h01, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h10});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h01});
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (valid && sop) break;
    end
    chk("t7_sop_seen", {valid, sop}, 2'b11);
    cyc();
    reset = 1'b1;
    @(negedge clock);
    chk("t7_no_sr_in_reset", {soft_reset, abort_p}, 4'd0);
    @(negedge clock);
    chk("t7_outputs_zero", {valid, data, sop, eop, abort_p, perr}, 15'd0);
    chk("t7_grant_rd_sr_zero", {grant, read_enb, soft_reset}, 9'd0);
    fq0.delete(); fq1.delete(); fq2.delete();
    refresh();
    cyc();
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_idle{grant,valid}", {grant, valid}, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
